// File: rtl/fc_weight_stream_ctrl_pkg.sv
// Shared definitions for the FC weight streaming controller and its output FIFO.
package fc_weight_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         WORD_BYTES   = 4;
  localparam int         WORD_SHIFT   = $clog2(WORD_BYTES);
  localparam logic [3:0] WEN_FULL     = 4'b1111;
  localparam int         BRAM_LATENCY = 1;
  // Output buffering needed to cover the read latency at one word per cycle.
  localparam int         FIFO_DEPTH   = BRAM_LATENCY + 1;

endpackage

// File: rtl/fc_wstream_fifo2.sv
// Two-entry output FIFO between the BRAM read port and the datapath handshake.
import fc_weight_stream_ctrl_pkg::*;

module fc_wstream_fifo2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  input  logic        flush,
  output logic [31:0] head,
  output logic [1:0]  count
);

  logic [31:0] head_q, head_d;
  logic [31:0] tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic        do_pop;
  logic        do_push;

  // Next-state for the head/tail slots; head always holds the oldest word.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = din;
          else                 tail_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = din;
          end else begin
            head_d = tail_q;
            tail_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign count = count_q;

endmodule

// File: rtl/fc_weight_stream_ctrl.sv
// Streams a contiguous run of weight words from a single-port BRAM to the FC
// datapath, and lends the BRAM port to the host loader whenever it is idle.
import fc_weight_stream_ctrl_pkg::*;

module fc_weight_stream_ctrl #(
  parameter int CNT_W     = 10,
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 1001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       w_data,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_din,
  output logic              host_ack,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  output logic [3:0]        bram_wen,
  output logic [31:0]       bram_din,
  input  logic [31:0]       bram_dout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_word_q, base_word_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  issue_idx_q, issue_idx_d;
  logic [CNT_W-1:0]  recv_idx_q, recv_idx_d;
  logic              inflight_q, inflight_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              active;
  logic              pop;
  logic              push;
  logic              flush;
  logic              issue;
  logic [1:0]        fifo_count;
  logic [31:0]       fifo_head;
  logic [ADDR_W-1:0] req_word;
  logic              reject;
  logic [2:0]        occupancy;

  fc_wstream_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bram_dout),
    .pop   (pop),
    .flush (flush),
    .head  (fifo_head),
    .count (fifo_count)
  );

  // Handshake, read-issue and host-grant decisions for the current cycle.
  always_comb begin
    active    = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    w_valid   = (fifo_count != 2'd0);
    w_data    = fifo_head;
    pop       = w_valid && w_ready;
    push      = active && !abort && inflight_q;
    flush     = active && abort;
    req_word  = base_addr >> WORD_SHIFT;
    reject    = (req_word + ADDR_W'(word_cnt)) > ADDR_W'(MAX_WORDS);
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    issue     = (state_q == ST_FETCH) && !abort && (issue_idx_q != word_cnt_q) &&
                (occupancy < (3'(FIFO_DEPTH) + {2'b00, pop}));
    host_ack  = rst && (state_q == ST_IDLE) && host_wr && !start;
    bram_en   = 1'b0;
    bram_wen  = 4'b0000;
    bram_addr = '0;
    bram_din  = '0;
    if (issue) begin
      bram_en   = 1'b1;
      bram_addr = (base_word_q + ADDR_W'(issue_idx_q)) << WORD_SHIFT;
    end else if (host_ack) begin
      bram_en   = 1'b1;
      bram_wen  = WEN_FULL;
      bram_addr = host_addr;
      bram_din  = host_din;
    end
  end

  // Sequencer next-state: accept/reject starts, advance counters, finish runs.
  always_comb begin
    state_d     = state_q;
    base_word_d = base_word_q;
    word_cnt_d  = word_cnt_q;
    issue_idx_d = issue_idx_q;
    recv_idx_d  = recv_idx_q;
    inflight_d  = issue;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (word_cnt == '0) begin
            state_d = ST_DONE;
          end else if (reject) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            base_word_d = req_word;
            word_cnt_d  = word_cnt;
            issue_idx_d = '0;
            recv_idx_d  = '0;
            state_d     = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          if (issue) issue_idx_d = issue_idx_q + CNT_W'(1);
          if (push)  recv_idx_d  = recv_idx_q + CNT_W'(1);
          if (issue_idx_d == word_cnt_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          if (push) recv_idx_d = recv_idx_q + CNT_W'(1);
          if ((recv_idx_q == word_cnt_q) && !push && (fifo_count == {1'b0, pop}))
            state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_word_q <= '0;
      word_cnt_q  <= '0;
      issue_idx_q <= '0;
      recv_idx_q  <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_word_q <= base_word_d;
      word_cnt_q  <= word_cnt_d;
      issue_idx_q <= issue_idx_d;
      recv_idx_q  <= recv_idx_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_fc_weight_stream_ctrl.sv
// Scoreboard bench for fc_weight_stream_ctrl with a behavioural BRAM model.
module tb_fc_weight_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [9:0]  word_cnt;
  logic        abort;
  logic        busy, done, err;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic        host_wr;
  logic [31:0] host_addr, host_din;
  logic        host_ack;
  logic [31:0] bram_addr;
  logic        bram_en;
  logic [3:0]  bram_wen;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] mem [0:1023];
  logic        stab_en;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  fc_weight_stream_ctrl #(.CNT_W(10), .ADDR_W(32), .MAX_WORDS(1001)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_cnt  (word_cnt),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .w_data    (w_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_din  (host_din),
    .host_ack  (host_ack),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_wen  (bram_wen),
    .bram_din  (bram_din),
    .bram_dout (bram_dout)
  );

  // Single-port BRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_wen == 4'hF) mem[bram_addr[11:2]] <= bram_din;
      else                  bram_dout <= mem[bram_addr[11:2]];
    end
  end

  // Scoreboard pop on every accepted word, plus hold-while-stalled check.
  always @(negedge clk) begin
    if (w_valid === 1'b1 && w_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_word: got %h, no word expected", w_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (w_data !== mon_exp) begin
          errors++;
          $display("[TB] FAIL stream_word: got %h, expected %h", w_data, mon_exp);
        end
      end
    end
    if (stab_en && prev_stall) begin
      checks++;
      if (w_valid !== 1'b1 || w_data !== prev_data) begin
        errors++;
        $display("[TB] FAIL stall_hold: valid=%b data=%h, expected valid=1 data=%h",
                 w_valid, w_data, prev_data);
      end
    end
    prev_stall = stab_en && (w_valid === 1'b1) && (w_ready === 1'b0);
    prev_data  = w_data;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start pulse (held until the caller's next edge) and queue the words a correct run delivers.
  task automatic launch(input logic [31:0] base, input logic [9:0] cnt);
    int bw;
    bw        = int'(base >> 2);
    start     = 1'b1;
    base_addr = base;
    word_cnt  = cnt;
    if (cnt != 0 && (bw + int'(cnt)) <= 1001)
      for (int i = 0; i < int'(cnt); i++) exp_q.push_back(ref_mem[bw + i]);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
      else tick();
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; w_ready = 0; host_wr = 0;
    base_addr = 0; word_cnt = 0; host_addr = 0; host_din = 0;
    stab_en = 1'b1; prev_stall = 1'b0;
    #2 rst = 1'b0;
    host_wr = 1'b1; host_addr = 32'h40; host_din = 32'h1234;
    #20;
    checks++;
    if ({busy, done, err, w_valid, host_ack, bram_en, bram_wen} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 0", {busy, done, err, w_valid, host_ack, bram_en, bram_wen});
    end
    checks++;
    if (bram_addr !== 32'h0 || w_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: addr=%h w_data=%h, expected 0", bram_addr, w_data);
    end
    host_wr = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
  endtask

  task automatic test_preload();
    for (int i = 0; i < 22; i++) begin
      int w;
      w = (i < 16) ? i : (995 + i - 16);
      host_wr = 1'b1; host_addr = w * 4;
      host_din = (i < 16) ? (32'hA000_0000 + w) : (32'hB000_0000 + w);
      @(negedge clk);
      checks++;
      if ({host_ack, bram_en, bram_wen} !== 6'h3F || bram_addr !== host_addr || bram_din !== host_din) begin
        errors++;
        $display("[TB] FAIL preload_write: ack/en/wen=%b addr=%h din=%h, expected 111111 %h %h",
                 {host_ack, bram_en, bram_wen}, bram_addr, bram_din, host_addr, host_din);
      end
      ref_mem[w] = host_din;
      tick();
    end
    host_wr = 1'b0;
    tick();
  endtask

  task automatic test_stream_full();
    logic ev, eb, ed;
    w_ready = 1'b1;
    launch(32'h10, 10'd8);
    tick();
    start = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      ev = (c >= 2 && c <= 9);
      eb = (c <= 9);
      ed = (c == 10);
      checks++;
      if ({w_valid, busy, done} !== {ev, eb, ed}) begin
        errors++;
        $display("[TB] FAIL full_timing c=%0d: valid/busy/done=%b, expected %b", c, {w_valid, busy, done}, {ev, eb, ed});
      end
      tick();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_complete: %0d words missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_stream_stall();
    logic [3:0] pat;
    int k;
    bit ok;
    pat = 4'b1001;
    k = 0; ok = 1'b0;
    w_ready = pat[0];
    launch(32'h10, 10'd8);
    tick();
    start = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
      else begin
        tick();
        k++;
        w_ready = pat[k % 4];
      end
    end
    tick();
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL stall_run: done=%b remaining=%0d, expected done=1 remaining=0", ok, exp_q.size());
    end
    w_ready = 1'b1;
  endtask

  task automatic test_host_write();
    bit ok;
    host_wr = 1'b1; host_addr = 32'h20; host_din = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b1 || bram_wen !== 4'hF) begin
      errors++;
      $display("[TB] FAIL host_write: ack=%b wen=%b, expected 1 1111", host_ack, bram_wen);
    end
    ref_mem[8] = 32'hDEAD_BEEF;
    tick();
    host_wr = 1'b1; host_addr = 32'h24; host_din = 32'h1234_5678;
    w_ready = 1'b1;
    launch(32'h20, 10'd1);
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_priority: ack=%b, expected 0", host_ack);
    end
    tick();
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0 || bram_wen !== 4'h0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL host_stall: ack=%b wen=%b busy=%b, expected 0 0000 1", host_ack, bram_wen, busy);
    end
    tick();
    wait_done(20, ok);
    host_wr = 1'b0;
    launch(32'h24, 10'd1);
    tick();
    start = 1'b0;
    wait_done(20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL host_readback: done=%b remaining=%0d, expected done=1 remaining=0", ok, exp_q.size());
    end
  endtask

  task automatic test_edge_starts();
    bit ok;
    for (int t = 0; t < 2; t++) begin
      logic exp_err;
      exp_err = (t == 1);
      launch((t == 0) ? 32'h0 : 32'hF9C, (t == 0) ? 10'd0 : 10'd3);
      tick();
      start = 1'b0;
      @(negedge clk);
      checks++;
      if ({done, err, busy, bram_en} !== {1'b1, exp_err, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL edge_start%0d: done/err/busy/en=%b, expected %b", t, {done, err, busy, bram_en}, {1'b1, exp_err, 2'b00});
      end
      tick();
      @(negedge clk);
      checks++;
      if ({done, err, bram_en} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL edge_after%0d: done/err/en=%b, expected 000", t, {done, err, bram_en});
      end
      tick();
    end
    w_ready = 1'b1;
    launch(32'hF98, 10'd3);
    tick();
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL top_of_mem_err: err=%b, expected 0", err);
        end
      end else tick();
    end
    tick();
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL top_of_mem: done=%b remaining=%0d, expected done=1 remaining=0", ok, exp_q.size());
    end
  endtask

  task automatic test_abort();
    int acc;
    bit ok;
    w_ready = 1'b1;
    launch(32'h0, 10'd10);
    tick();
    start = 1'b0;
    acc = 0;
    for (int c = 0; c < 30 && acc < 3; c++) begin
      @(negedge clk);
      if (w_valid === 1'b1 && w_ready === 1'b1) acc++;
      tick();
      if (acc >= 3) w_ready = 1'b0;
    end
    checks++;
    if (acc != 3) begin
      errors++;
      $display("[TB] FAIL abort_prefix: accepted %0d, expected 3", acc);
    end
    tick();
    tick();
    stab_en = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if ({done, err, w_valid, busy} !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL abort_end: done/err/valid/busy=%b, expected 1000", {done, err, w_valid, busy});
    end
    tick();
    @(negedge clk);
    checks++;
    if ({done, w_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL abort_after: done/valid=%b, expected 00", {done, w_valid});
    end
    stab_en = 1'b1;
    tick();
    w_ready = 1'b1;
    launch(32'h14, 10'd4);
    tick();
    start = 1'b0;
    wait_done(30, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL abort_restart: done=%b remaining=%0d, expected done=1 remaining=0", ok, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    w_ready = 1'b1;
    launch(32'h0, 10'd12);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, w_valid, bram_en, bram_wen} !== 9'b0 || bram_addr !== 32'h0 || w_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: ctrl=%b addr=%h data=%h, expected all 0",
               {busy, done, err, w_valid, bram_en, bram_wen}, bram_addr, w_data);
    end
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    host_wr = 1'b1; host_addr = 32'h30; host_din = 32'h5555_AAAA;
    @(negedge clk);
    checks++;
    if ({host_ack, bram_wen, busy} !== 6'b111110) begin
      errors++;
      $display("[TB] FAIL post_reset_write: ack/wen/busy=%b, expected 111110", {host_ack, bram_wen, busy});
    end
    ref_mem[12] = 32'h5555_AAAA;
    tick();
    host_wr = 1'b0;
    launch(32'h30, 10'd1);
    tick();
    start = 1'b0;
    wait_done(20, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL post_reset_stream: done=%b remaining=%0d, expected done=1 remaining=0", ok, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_stream_full();
    test_stream_stall();
    test_host_write();
    test_edge_starts();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
